// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with a mem_ready handshake and wait timeout.
// Define ILLEGAL_HALT_EN to park in HALT on an illegal op (default: illegal op is a NOP back to FETCH).
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] left_shift,
    output logic       reg_write,
    output logic [1:0] reg_src,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state_o
);
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ALUR, C_ALUI, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI
    } cls_t;

    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] fn);
        cls_t c;
        c = C_ILL;
        case (op)
            7'b0110011: if (fn == 3'b000 || fn == 3'b100 || fn == 3'b110) c = C_ALUR;
            7'b0010011: if (fn == 3'b000 || fn == 3'b100 || fn == 3'b001) c = C_ALUI;
            7'b0000011: if (fn == 3'b010) c = C_LW;
            7'b0100011: if (fn == 3'b010) c = C_SW;
            7'b1100011: if (fn == 3'b000 || fn == 3'b100 || fn == 3'b101) c = C_BR;
            7'b1101111: c = C_JAL;
            7'b1100111: if (fn == 3'b000) c = C_JALR;
            7'b0110111: c = C_LUI;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic [6:0]      op_q, op_d;
    logic [2:0]      fn_q, fn_d;
    cls_t            cls_dec, cls_q;
    logic            mem_phase, timeout;

    assign cls_dec   = classify(opcode, func);
    assign cls_q     = classify(op_q, fn_q);
    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = (wait_q == CW'(MEM_TIMEOUT - 1)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls_dec == C_LUI)      state_d = S_WB;
`ifdef ILLEGAL_HALT_EN
                else if (cls_dec == C_ILL) state_d = S_HALT;
`else
                else if (cls_dec == C_ILL) state_d = S_FETCH;
`endif
                else                       state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW:     state_d = S_MEM;
                    C_ALUR, C_ALUI: state_d = S_WB;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                else if (timeout) state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // A timeout in FETCH stays in FETCH, so the counter is cleared explicitly rather than by a state change.
    always_comb begin
        wait_d = '0;
        if (mem_phase && !mem_ready && !timeout) wait_d = wait_q + 1'b1;
        err_d = err_q | (mem_phase && timeout);
        op_d  = (state_q == S_DECODE) ? opcode : op_q;
        fn_d  = (state_q == S_DECODE) ? func   : fn_q;
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        left_shift = 2'b00;
        reg_write  = 1'b0;
        reg_src    = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                illegal   = (cls_dec == C_ILL);
            end
            S_EXEC: begin
                case (cls_q)
                    C_ALUR: begin
                        alu_src_a = 1'b1;
                        alu_op    = (fn_q == 3'b000) ? 2'b10 : 2'b11;
                    end
                    C_ALUI: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = 2'b10;
                        alu_op     = (fn_q == 3'b100) ? 2'b11 : 2'b10;
                        left_shift = (fn_q == 3'b001) ? 2'b01 : 2'b00;
                    end
                    C_LW, C_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    C_BR: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_src    = 2'b01;
                        pc_write  = ((fn_q == 3'b000) && alu_zero) ||
                                    ((fn_q == 3'b100) && alu_lt)   ||
                                    ((fn_q == 3'b101) && !alu_lt);
                    end
                    C_JAL, C_JALR: begin
                        pc_write  = 1'b1;
                        pc_src    = (cls_q == C_JAL) ? 2'b10 : 2'b11;
                        reg_write = 1'b1;
                        reg_src   = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q == C_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_src    = (cls_q == C_LW)  ? 2'b01 : 2'b00;
                left_shift = (cls_q == C_LUI) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign mem_err = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] func = '0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_write, pc_write, alu_src_a, reg_write, illegal, mem_err;
    logic [1:0] pc_src, alu_src_b, alu_op, left_shift, reg_src;
    logic [2:0] state_o;

    multi_cycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .left_shift(left_shift), .reg_write(reg_write),
        .reg_src(reg_src), .illegal(illegal), .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam int TO = 16;
    localparam int K_ILL = 0, K_ALUR = 1, K_ALUI = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_JAL = 6, K_JALR = 7, K_LUI = 8;

    typedef struct {
        logic [2:0]  st;
        logic        rdy, zero, lt, to;
        logic [6:0]  op;
        logic [2:0]  fn;
        logic [17:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   n_chk = 0, n_err = 0;
    logic err_m = 1'b0;

    localparam logic [6:0] OPS [17] = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h03, 7'h23,
                                        7'h63, 7'h63, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h0f, 7'h33, 7'h03};
    localparam logic [2:0] FNS [17] = '{3'd0, 3'd4, 3'd6, 3'd0, 3'd4, 3'd1, 3'd2, 3'd2,
                                        3'd0, 3'd4, 3'd5, 3'd3, 3'd0, 3'd7, 3'd0, 3'd1, 3'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Packed view of the control word: {rd,wr,iord,irw,pcw,pcs,rw,rs,ill,lsh,aop,sa,sb}
    function automatic logic [17:0] pk(input logic mr, mw, io, irw, pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] rs, input logic ill,
                                       input logic [1:0] lsh, aop, input logic sa, input logic [1:0] sb);
        return {mr, mw, io, irw, pcw, pcs, rw, rs, ill, lsh, aop, sa, sb};
    endfunction

    function automatic int kind(input logic [6:0] op, input logic [2:0] fn);
        case (op)
            7'h33:   return (fn == 0 || fn == 4 || fn == 6) ? K_ALUR : K_ILL;
            7'h13:   return (fn == 0 || fn == 4 || fn == 1) ? K_ALUI : K_ILL;
            7'h03:   return (fn == 2) ? K_LW : K_ILL;
            7'h23:   return (fn == 2) ? K_SW : K_ILL;
            7'h63:   return (fn == 0 || fn == 4 || fn == 5) ? K_BR : K_ILL;
            7'h6f:   return K_JAL;
            7'h67:   return (fn == 0) ? K_JALR : K_ILL;
            7'h37:   return K_LUI;
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input logic [2:0] st, input logic rdy, zero, lt, to,
                        input logic [6:0] op, input logic [2:0] fn, input logic [17:0] exp);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.zero = zero; c.lt = lt; c.to = to; c.op = op; c.fn = fn; c.exp = exp;
        q.push_back(c);
    endtask

    // Fetch with w wait cycles; w >= TO means the access times out and nothing is loaded.
    task automatic gen_fetch(input int w, output bit ok);
        int n;
        n = (w >= TO) ? TO : w;
        for (int i = 0; i < n; i++)
            push(3'd1, 1'b0, 1'($urandom), 1'($urandom), (w >= TO) && (i == TO - 1), 7'($urandom), 3'($urandom),
                 pk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
        ok = (w < TO);
        if (ok)
            push(3'd1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 7'($urandom), 3'($urandom),
                 pk(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
    endtask

    // mcut > 0: stop after mcut unanswered MEM cycles (used for the reset-mid-access case).
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] fn, input int fw, input int mw,
                             input logic zero, input logic lt, input int mcut);
        bit ok;
        int k, n;
        logic taken, is_lw;
        logic [1:0] aop, lsh;
        gen_fetch(fw, ok);
        if (!ok) gen_fetch(0, ok);
        k = kind(op, fn);
        push(3'd2, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, op, fn,
             pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, k == K_ILL, 2'b00, 2'b00, 0, 2'b10));
        if (k == K_ILL) return;
        if (k == K_LUI) begin
            push(3'd5, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, op, fn,
                 pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b10, 2'b00, 0, 2'b00));
            return;
        end
        case (k)
            K_ALUR: push(3'd3, 1'($urandom), zero, lt, 1'b0, op, fn,
                         pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, (fn == 0) ? 2'b10 : 2'b11, 1, 2'b00));
            K_ALUI: begin
                aop = (fn == 4) ? 2'b11 : 2'b10;
                lsh = (fn == 1) ? 2'b01 : 2'b00;
                push(3'd3, 1'($urandom), zero, lt, 1'b0, op, fn,
                     pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, lsh, aop, 1, 2'b10));
            end
            K_LW, K_SW: push(3'd3, 1'($urandom), zero, lt, 1'b0, op, fn,
                             pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10));
            K_BR: begin
                taken = (fn == 0 && zero) || (fn == 4 && lt) || (fn == 5 && !lt);
                push(3'd3, 1'($urandom), zero, lt, 1'b0, op, fn,
                     pk(0, 0, 0, 0, taken, 2'b01, 0, 2'b00, 0, 2'b00, 2'b01, 1, 2'b00));
            end
            default: push(3'd3, 1'($urandom), zero, lt, 1'b0, op, fn,
                          pk(0, 0, 0, 0, 1, (k == K_JAL) ? 2'b10 : 2'b11, 1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00));
        endcase
        if (k == K_LW || k == K_SW) begin
            is_lw = (k == K_LW);
            n = (mcut > 0) ? mcut : ((mw >= TO) ? TO : mw);
            for (int i = 0; i < n; i++)
                push(3'd4, 1'b0, 1'($urandom), 1'($urandom), (mcut == 0) && (mw >= TO) && (i == TO - 1), op, fn,
                     pk(is_lw, !is_lw, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
            if (mcut > 0 || mw >= TO) return;
            push(3'd4, 1'b1, 1'($urandom), 1'($urandom), 1'b0, op, fn,
                 pk(is_lw, !is_lw, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
            if (!is_lw) return;
        end
        if (k == K_LW || k == K_ALUR || k == K_ALUI)
            push(3'd5, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, op, fn,
                 pk(0, 0, 0, 0, 0, 2'b00, 1, (k == K_LW) ? 2'b01 : 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
    endtask

    function automatic logic [17:0] obs_word();
        return {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, reg_src,
                illegal, left_shift, alu_op, alu_src_a, alu_src_b};
    endfunction

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst = 1'b0; opcode = c.op; func = c.fn; mem_ready = c.rdy; alu_zero = c.zero; alu_lt = c.lt;
            #1;
            check("state", 32'(state_o), 32'(c.st));
            check("outs", 32'(obs_word()), 32'(c.exp));
            check("mem_err", 32'(mem_err), 32'(err_m));
            if (c.to) err_m = 1'b1;
        end
    endtask

    initial begin
        int idx, r1, r2;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_outs", 32'(obs_word()), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);

        push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h0, 3'h0, 18'd0);
        gen_instr(7'h33, 3'd0, 0, 0, 1'b0, 1'b0, 0);   // ADD, ready tied high
        gen_instr(7'h03, 3'd2, 0, 3, 1'b0, 1'b0, 0);   // LW, 3 MEM waits
        gen_instr(7'h63, 3'd5, 0, 0, 1'b0, 1'b0, 0);   // BGE taken
        gen_instr(7'h63, 3'd5, 0, 0, 1'b0, 1'b1, 0);   // BGE not taken
        gen_instr(7'h33, 3'd4, TO, 0, 1'b0, 1'b0, 0);  // fetch timeout then XOR
        gen_instr(7'h0f, 3'd0, 0, 0, 1'b0, 1'b0, 0);   // illegal opcode
        gen_instr(7'h37, 3'd0, 1, 0, 1'b0, 1'b0, 0);   // LUI
        gen_instr(7'h23, 3'd2, 0, TO, 1'b0, 1'b0, 0);  // SW with MEM timeout
        run_q();

        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, 16);
            r1 = $urandom_range(0, 24);
            r2 = $urandom_range(0, 24);
            gen_instr(OPS[idx], FNS[idx], (r1 == 0) ? TO : r1 % 4, (r2 == 0) ? TO : r2 % 4,
                      1'($urandom), 1'($urandom), 0);
            run_q();
        end

        gen_instr(7'h23, 3'd2, 0, 0, 1'b0, 1'b0, 2);    // SW stuck in MEM, then reset
        run_q();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        check("rst_drop_mw", 32'(mem_write), 32'd0);
        @(negedge clk);
        #1;
        check("rst_mid_state", 32'(state_o), 32'd0);
        check("rst_mid_outs", 32'(obs_word()), 32'd0);
        check("rst_mid_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
        err_m = 1'b0;
        push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 3'h0, pk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
